// File: rtl/matrix_dma_pkg.sv
// Shared types and constants for the matrix DMA round-robin arbiter.
package matrix_dma_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StRelease = 2'd2
  } arb_state_e;

  localparam int unsigned DefAw = 32;
  localparam int unsigned DefDw = 32;

  // Read data returned to the owner when memory never answers.
  localparam logic [31:0] TimeoutPoison = 32'hDEAD_BEEF;

endpackage

// File: rtl/matrix_dma_arbiter_if.sv
// Requester-side and memory-side signals of the DMA arbiter.
// master: arbiter view; slave: requesters plus memory.
interface matrix_dma_arbiter_if
  import matrix_dma_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = DefAw,
  parameter int unsigned DW   = DefDw
);

  logic [NREQ-1:0]    req_i;
  logic [NREQ-1:0]    we_i;
  logic [NREQ*AW-1:0] addr_i;
  logic [NREQ*DW-1:0] wdata_i;
  logic [NREQ-1:0]    ack_o;
  logic [DW-1:0]      rdata_o;
  logic [NREQ-1:0]    grant_o;
  logic               err_o;
  logic               mem_req;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_ack;
  logic [DW-1:0]      mem_rdata;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, mem_ack, mem_rdata,
    output ack_o, rdata_o, grant_o, err_o, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, mem_ack, mem_rdata,
    input  ack_o, rdata_o, grant_o, err_o, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/matrix_dma_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above pointer, with wrap.
module rr_pick #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   winner_idx
);

  logic found;
  int   k;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    k          = 0;
    for (int i = 0; i < int'(NREQ); i++) begin
      k = (int'(pointer) + i) % int'(NREQ);
      if (!found && req[k]) begin
        found      = 1'b1;
        winner[k]  = 1'b1;
        winner_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/matrix_dma_arbiter.sv
// Round-robin arbiter sharing one single-word DMA memory port among NREQ requesters.
// Optional bus timeout with poisoned completion: define ARB_TIMEOUT_EN.
module matrix_dma_arbiter
  import matrix_dma_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic                  clk,
  input logic                  reset,
  matrix_dma_arbiter_if.master bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e      state_q;
  logic [NREQ-1:0] grant_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;

  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   ptr_adv;
  logic            timeout;
  logic            done;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req        (bus.req_i),
    .pointer    (ptr_q),
    .winner     (win_onehot),
    .winner_idx (win_idx)
  );

  assign ptr_adv = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  // Zero on every cycle outside BUSY, so the count restarts on each grant.
  always_ff @(posedge clk) begin
    if (reset || state_q != StBusy) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == StBusy) && !bus.mem_ack && (cnt_q == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  assign done = (state_q == StBusy) && (bus.mem_ack || timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      ptr_q       <= '0;
      owner_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|bus.req_i) begin
            state_q     <= StBusy;
            grant_q     <= win_onehot;
            owner_q     <= win_idx;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.we_i[win_idx];
            mem_addr_q  <= bus.addr_i[int'(win_idx)*AW +: AW];
            mem_wdata_q <= bus.wdata_i[int'(win_idx)*DW +: DW];
          end
        end
        StBusy: begin
          if (done) begin
            state_q   <= StRelease;
            mem_req_q <= 1'b0;
            grant_q   <= '0;
            ptr_q     <= ptr_adv;
          end
        end
        StRelease: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack_o     = done ? grant_q : '0;
  assign bus.rdata_o   = timeout ? DW'(TimeoutPoison) : bus.mem_rdata;
  assign bus.err_o     = timeout;
  assign bus.grant_o   = grant_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_matrix_dma_arbiter.sv
// Directed bench for matrix_dma_arbiter with a scoreboard of expected memory transactions.
module tb_matrix_dma_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [1:0]  owner;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];

  matrix_dma_arbiter_if #(.NREQ(2), .AW(32), .DW(32)) bus ();

  matrix_dma_arbiter #(
    .NREQ    (2),
    .AW      (32),
    .DW      (32),
    .TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic on, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.req_i[k]          = on;
    bus.we_i[k]           = we;
    bus.addr_i[k*32 +: 32]  = addr;
    bus.wdata_i[k*32 +: 32] = wdata;
  endtask

  task automatic push(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                      input logic [1:0] owner);
    exp_t e;
    e.addr  = addr;
    e.we    = we;
    e.wdata = wdata;
    e.owner = owner;
    sb.push_back(e);
  endtask

  // Waits for a grant, checks it against the scoreboard head, then acks after lat cycles.
  task automatic serve(input int lat, input logic [31:0] rdata);
    exp_t e;
    logic [1:0] exp_onehot;
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.mem_req !== 1'b1) begin
      check("grant_wait", {63'd0, bus.mem_req}, 64'd1);
      return;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    exp_onehot = 2'b01 << e.owner;
    check("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
    check("mem_we", 64'(bus.mem_we), 64'(e.we));
    check("mem_wdata", 64'(bus.mem_wdata), 64'(e.wdata));
    check("grant_o", 64'(bus.grant_o), 64'(exp_onehot));
    repeat (lat) @(negedge clk);
    check("ack_before_mem_ack", 64'(bus.ack_o), 64'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    #1;
    check("ack_o", 64'(bus.ack_o), 64'(exp_onehot));
    check("rdata_o", 64'(bus.rdata_o), 64'(rdata));
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("mem_req_drop", 64'(bus.mem_req), 64'd0);
    check("ack_after", 64'(bus.ack_o), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req_i = '0;
    bus.we_i = '0;
    bus.addr_i = '0;
    bus.wdata_i = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ack", 64'(bus.ack_o), 64'd0);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_grant", 64'(bus.grant_o), 64'd0);
    check("rst_err", 64'(bus.err_o), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single read from requester 0, one-cycle grant latency
    set_req(0, 1'b1, 1'b0, 32'h1000, 32'h0);
    push(32'h1000, 1'b0, 32'h0, 2'd0);
    #1;
    check("t1_latency_low", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    check("t1_latency_high", 64'(bus.mem_req), 64'd1);
    serve(3, 32'd7);
    set_req(0, 1'b0, 1'b0, 32'h1000, 32'h0);
    repeat (3) @(negedge clk);

    // Requester 1 write; pointer then favours 0
    set_req(1, 1'b1, 1'b1, 32'h3000, 32'd58);
    push(32'h3000, 1'b1, 32'd58, 2'd1);
    @(negedge clk);
    serve(1, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);

    // Both hold: grants alternate 0,1,0,1
    set_req(0, 1'b1, 1'b0, 32'h1000, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h2000, 32'h0);
    push(32'h1000, 1'b0, 32'h0, 2'd0);
    push(32'h2000, 1'b0, 32'h0, 2'd1);
    push(32'h1000, 1'b0, 32'h0, 2'd0);
    push(32'h2000, 1'b0, 32'h0, 2'd1);
    for (int i = 0; i < 4; i++) serve(1, 32'(100 + i));
    bus.req_i = '0;
    repeat (3) @(negedge clk);

    // Reset while BUSY, then a stray mem_ack
    set_req(1, 1'b1, 1'b0, 32'h4000, 32'h0);
    @(negedge clk);
    check("t4_busy", 64'(bus.mem_req), 64'd1);
    reset = 1'b1;
    bus.req_i = '0;
    @(negedge clk);
    reset = 1'b0;
    check("t4_mem_req", 64'(bus.mem_req), 64'd0);
    check("t4_grant", 64'(bus.grant_o), 64'd0);
    check("t4_addr", 64'(bus.mem_addr), 64'd0);
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 32'h1234;
    #1;
    check("t4_stray_ack", 64'(bus.ack_o), 64'd0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("t4_no_req", 64'(bus.mem_req), 64'd0);
    set_req(0, 1'b1, 1'b0, 32'h5000, 32'h0);
    set_req(1, 1'b1, 1'b1, 32'h6000, 32'hA5);
    push(32'h5000, 1'b0, 32'h0, 2'd0);
    push(32'h6000, 1'b1, 32'hA5, 2'd1);
    serve(2, 32'h11);
    bus.req_i[0] = 1'b0;
    serve(2, 32'h22);
    bus.req_i = '0;
    repeat (3) @(negedge clk);

    // Requester 0 drops req mid-BUSY; transaction still completes once
    set_req(0, 1'b1, 1'b1, 32'h7000, 32'h55);
    push(32'h7000, 1'b1, 32'h55, 2'd0);
    @(negedge clk);
    bus.req_i = '0;
    serve(2, 32'h33);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_extra_ack", 64'(bus.ack_o), 64'd0);
      check("t5_no_req", 64'(bus.mem_req), 64'd0);
    end

`ifdef ARB_TIMEOUT_EN
    // No mem_ack: timeout in BUSY cycle 16, then requester 1 is served
    set_req(0, 1'b1, 1'b0, 32'h8000, 32'h0);
    @(negedge clk);
    check("t6_busy", 64'(bus.mem_req), 64'd1);
    bus.req_i = '0;
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) begin
        check("t6_err_early", 64'(bus.err_o), 64'd0);
        check("t6_ack_early", 64'(bus.ack_o), 64'd0);
        @(negedge clk);
      end else begin
        check("t6_err", 64'(bus.err_o), 64'd1);
        check("t6_ack", 64'(bus.ack_o), 64'd1);
        check("t6_poison", 64'(bus.rdata_o), 64'hDEADBEEF);
      end
    end
    @(negedge clk);
    check("t6_err_clear", 64'(bus.err_o), 64'd0);
    check("t6_req_drop", 64'(bus.mem_req), 64'd0);
    set_req(1, 1'b1, 1'b0, 32'h9000, 32'h0);
    push(32'h9000, 1'b0, 32'h0, 2'd1);
    serve(1, 32'h44);
    bus.req_i = '0;
    repeat (2) @(negedge clk);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_dma_arbiter.md
Name: matrix_dma_arbiter

Overview:
- Round-robin arbiter that shares one memory-side DMA port among NREQ requesters.
- Requesters are the matrix accelerator's load/store engine, a second accelerator instance, and the CPU bridge.
- Each requester uses the accelerator's native handshake: dma_req/dma_ack/dma_addr/dma_we/dma_data.
- One transaction (single 32-bit word) is in flight at a time. Transaction attributes are registered at grant, so the memory side sees stable signals.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 1024, cycles to wait for mem_ack before abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_i  in  NREQ  per-requester dma_req
- we_i  in  NREQ  per-requester dma_we
- addr_i  in  NREQ*AW  packed addresses; requester k uses bits [k*AW +: AW]
- wdata_i  in  NREQ*DW  packed write data
- ack_o  out  NREQ  per-requester dma_ack, one-hot or zero
- rdata_o  out  DW  read data, shared by all requesters, valid while the matching ack_o bit is high
- mem_req  out  1  memory-side request
- mem_we  out  1  memory-side write enable
- mem_addr  out  AW  memory-side address
- mem_wdata  out  DW  memory-side write data
- mem_ack  in  1  memory-side acknowledge, single-cycle pulse
- mem_rdata  in  DW  memory-side read data, valid with mem_ack
- grant_o  out  NREQ  one-hot current owner (debug/visibility)
- err_o  out  1  timeout pulse (ARB_TIMEOUT_EN only)

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ack_o=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, grant_o=0, err_o=0; round-robin pointer=0, so requester 0 has highest priority first.
- Reset asserted mid-transaction drops mem_req on the next edge. Any later mem_ack is ignored.
- State IDLE:
  - If any req_i bit is high, choose the winner W = first set bit searching from pointer upward with wrap-around.
  - Register we_i[W], addr_i[W], wdata_i[W] into mem_*. Set grant_o=1<<W and mem_req=1. Go to BUSY.
  - Latency: mem_req rises the edge after req_i is sampled (1 cycle).
- State BUSY:
  - mem_* are held constant and req_i changes are ignored.
  - On mem_ack=1:
    - ack_o = grant_o (combinational, same cycle as mem_ack).
    - rdata_o = mem_rdata (combinational pass-through).
    - Next edge: mem_req=0, grant_o=0, pointer=(W+1) mod NREQ; go to RELEASE.
- State RELEASE:
  - One dead cycle so the requester can deassert or update its req after ack.
  - Returns to IDLE unconditionally.
  - Back-to-back throughput per owner is therefore 1 word per 3 cycles plus memory latency.
- Fairness: after serving W, W has lowest priority. With all requesters active, grants rotate 0,1,...,NREQ-1,0.
- A requester dropping req_i while BUSY does not abort the transaction. The transaction completes and the ack pulse is still issued; the requester must ignore it.
- mem_ack while IDLE or RELEASE is ignored: ack_o stays 0.
- rdata_o is undefined (pass-through) when no ack_o bit is set.
- NREQ=1 degenerates to a registered pass-through with the same state sequence.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A cycle counter runs in BUSY.
  - If it reaches TIMEOUT-1 without mem_ack: pulse err_o for 1 cycle, drop mem_req, assert ack_o of the owner for that cycle with rdata_o=32'hDEAD_BEEF, advance pointer, go to RELEASE.
  - The counter clears on entering BUSY.
- Undefined: no counter; err_o tied 0; BUSY waits indefinitely.

Decomposition:
- Package matrix_dma_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2), default AW/DW constants, the timeout poison value.
- Sub-module rr_pick: combinational round-robin priority picker; inputs req and pointer, outputs a one-hot winner and its index.

Test Plan:
- Single requester 0 read addr 0x1000; mem_ack after 3 cycles with rdata 7 -> mem_req one cycle after req; ack_o=2'b01 and rdata_o=7 in the mem_ack cycle; mem_req low the next cycle.
- Requesters 0 (addr 0x1000) and 1 (addr 0x2000) request simultaneously and hold -> order 0,1,0,1; mem_addr alternates 0x1000/0x2000; ack_o never 2'b11.
- Requester 1 write 0x3000 data 58 while requester 0 is idle -> mem_we=1, mem_wdata=58, mem_addr=0x3000; pointer then favours 0.
- Reset pulsed while BUSY, then a stray mem_ack -> all outputs 0; no ack_o; next grant goes to requester 0.
- Requester 0 drops req mid-BUSY -> transaction still completes; ack_o[0] pulses once.
- With ARB_TIMEOUT_EN and TIMEOUT=16, no mem_ack -> err_o and ack_o[0] pulse at cycle 16 of BUSY; rdata_o=32'hDEADBEEF; arbiter recovers and serves requester 1.
